// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the mem_cache slice:
//   - CACHE_WORD_SIZE : default data/address word width
//   - cache_state_t   : controller FSM state encoding
//   - clog2()         : field-width helper for offset/index/tag splits
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int CACHE_WORD_SIZE = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TAG,
      ST_WRITEBACK,
      ST_FILL,
      ST_RESPOND
   } cache_state_t;

   function automatic int clog2(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// -----------------------------------------------------------------------------
// cache_way_array
// Storage for one way: per-set valid, dirty, tag and data line.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears valid/dirty)
//   rd_index        set being looked up
//   rd_valid/dirty  state bits of that set
//   rd_tag/rd_line  tag and full line of that set (combinational read)
//   we, wr_index    single write port enable and target set
//   wr_valid/dirty  new state bits
//   wr_tag/wr_line  new tag and full line
// -----------------------------------------------------------------------------
module cache_way_array
   import cache_pkg::*;
#(
   parameter  int SETS   = 4,
   parameter  int TAG_W  = 12,
   parameter  int LINE_W = 64,
   localparam int IDX_W  = clog2(SETS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_index,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic              wr_valid,
   input  logic              wr_dirty,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line
);

   logic [SETS-1:0]   valid;
   logic [SETS-1:0]   dirty;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] data_mem [SETS];

   // Only the state bits are reset; tag/data are don't-care while invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (we) begin
         valid[wr_index] <= wr_valid;
         dirty[wr_index] <= wr_dirty;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_line;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_dirty = dirty[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/mem_cache.sv
// -----------------------------------------------------------------------------
// mem_cache
// Write-back, write-allocate, 1- or 2-way set-associative cache between the
// datapath request port and a line-wide memory port.
// Ports:
//   clk, reset_n                  clock, asynchronous active-high reset
//   read_cache, write_cache       requests, held until ready_cache
//   address_cache, wdata_cache    word address and store data
//   rdata_cache, ready_cache      load data and one-cycle completion pulse
//   doneWrite                     completion pulse for writes
//   address_memory                line base for readM/writeM
//   readM, writeM, mem_ack        line fill / writeback handshake
//   mem_wdata, mem_rdata          victim line out, fill line in (word 0 LSBs)
//   hit_count, access_count       wrapping statistics counters
// -----------------------------------------------------------------------------
module mem_cache
   import cache_pkg::*;
#(
   parameter int WORD_SIZE  = CACHE_WORD_SIZE,
   parameter int WAYS       = 2,
   parameter int SETS       = 4,
   parameter int LINE_WORDS = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            read_cache,
   input  logic                            write_cache,
   input  logic [WORD_SIZE-1:0]            address_cache,
   input  logic [WORD_SIZE-1:0]            wdata_cache,
   output logic [WORD_SIZE-1:0]            rdata_cache,
   output logic                            ready_cache,
   output logic                            doneWrite,
   output logic [WORD_SIZE-1:0]            address_memory,
   output logic                            readM,
   output logic                            writeM,
   output logic [LINE_WORDS*WORD_SIZE-1:0] mem_wdata,
   input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
   input  logic                            mem_ack,
   output logic [15:0]                     hit_count,
   output logic [15:0]                     access_count
);

   localparam int OFF_W  = clog2(LINE_WORDS);
   localparam int IDX_W  = clog2(SETS);
   localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
   localparam int LINE_W = LINE_WORDS * WORD_SIZE;

   cache_state_t         state;
   logic [WORD_SIZE-1:0] addr_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic                 op_write_q;
   logic                 way_q;      // hit way, or victim way on a miss
   logic [SETS-1:0]      lru;        // per set: the way to evict next

   logic [TAG_W-1:0]     tag_q;
   logic [IDX_W-1:0]     idx_q;
   logic [OFF_W-1:0]     off_q;

   assign tag_q = addr_q[WORD_SIZE-1 -: TAG_W];
   assign idx_q = addr_q[OFF_W +: IDX_W];
   assign off_q = addr_q[0 +: OFF_W];

   function automatic logic [WORD_SIZE-1:0] get_word(input logic [LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off);
      return line[int'(off)*WORD_SIZE +: WORD_SIZE];
   endfunction

   function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0]    line,
                                                  input logic [OFF_W-1:0]     off,
                                                  input logic [WORD_SIZE-1:0] word);
      logic [LINE_W-1:0] res;
      res = line;
      res[int'(off)*WORD_SIZE +: WORD_SIZE] = word;
      return res;
   endfunction

   function automatic logic [WORD_SIZE-1:0] line_base(input logic [TAG_W-1:0] tag,
                                                      input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

   // Way storage is always modelled as two slots; the second is tied off
   // when WAYS=1 so it can never hit or be chosen as a victim.
   logic [1:0]        rd_valid;
   logic [1:0]        rd_dirty;
   logic [TAG_W-1:0]  rd_tag  [2];
   logic [LINE_W-1:0] rd_line [2];
   logic [1:0]        we;
   logic              wr_valid;
   logic              wr_dirty;
   logic [TAG_W-1:0]  wr_tag;
   logic [LINE_W-1:0] wr_line;

   for (genvar w = 0; w < 2; w++) begin : g_way
      if (w < WAYS) begin : g_inst
         cache_way_array #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
         ) u_way (
            .clk      (clk),
            .rst      (reset_n),
            .rd_index (idx_q),
            .rd_valid (rd_valid[w]),
            .rd_dirty (rd_dirty[w]),
            .rd_tag   (rd_tag[w]),
            .rd_line  (rd_line[w]),
            .we       (we[w]),
            .wr_index (idx_q),
            .wr_valid (wr_valid),
            .wr_dirty (wr_dirty),
            .wr_tag   (wr_tag),
            .wr_line  (wr_line)
         );
      end else begin : g_tie
         assign rd_valid[w] = 1'b0;
         assign rd_dirty[w] = 1'b0;
         assign rd_tag[w]   = '0;
         assign rd_line[w]  = '0;
      end
   end

   logic [1:0] hit_vec;
   logic       hit_any;
   logic       hit_way;
   logic       victim;

   assign hit_vec[0] = rd_valid[0] && (rd_tag[0] == tag_q);
   assign hit_vec[1] = rd_valid[1] && (rd_tag[1] == tag_q);
   assign hit_any    = |hit_vec;
   assign hit_way    = hit_vec[1];

   always_comb begin
      if (WAYS == 1)         victim = 1'b0;
      else if (!rd_valid[0]) victim = 1'b0;
      else if (!rd_valid[1]) victim = 1'b1;
      else                   victim = lru[idx_q];
   end

   // Array write port: write hit, dirty clear after writeback, line install.
   always_comb begin
      we       = '0;
      wr_valid = 1'b1;
      wr_dirty = 1'b0;
      wr_tag   = tag_q;
      wr_line  = rd_line[way_q];
      case (state)
         ST_TAG: begin
            if (hit_any && op_write_q) begin
               we[hit_way] = 1'b1;
               wr_dirty    = 1'b1;
               wr_line     = put_word(rd_line[hit_way], off_q, wdata_q);
            end
         end
         ST_WRITEBACK: begin
            if (mem_ack) begin
               we[way_q] = 1'b1;
               wr_tag    = rd_tag[way_q];
            end
         end
         ST_FILL: begin
            if (mem_ack) begin
               we[way_q] = 1'b1;
               wr_dirty  = op_write_q;
               wr_line   = op_write_q ? put_word(mem_rdata, off_q, wdata_q) : mem_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state          <= ST_IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         op_write_q     <= 1'b0;
         way_q          <= 1'b0;
         lru            <= '0;
         rdata_cache    <= '0;
         ready_cache    <= 1'b0;
         doneWrite      <= 1'b0;
         address_memory <= '0;
         readM          <= 1'b0;
         writeM         <= 1'b0;
         mem_wdata      <= '0;
         hit_count      <= '0;
         access_count   <= '0;
      end else begin
         ready_cache <= 1'b0;
         doneWrite   <= 1'b0;
         case (state)
            ST_IDLE: begin
               // The cycle showing ready_cache still sees the old request held.
               if ((read_cache || write_cache) && !ready_cache) begin
                  addr_q       <= address_cache;
                  wdata_q      <= wdata_cache;
                  op_write_q   <= write_cache;
                  access_count <= access_count + 16'd1;
                  state        <= ST_TAG;
               end
            end
            ST_TAG: begin
               if (hit_any) begin
                  hit_count    <= hit_count + 16'd1;
                  way_q        <= hit_way;
                  lru[idx_q]   <= ~hit_way;
                  state        <= ST_RESPOND;
               end else begin
                  way_q <= victim;
                  if (rd_valid[victim] && rd_dirty[victim]) begin
                     writeM         <= 1'b1;
                     address_memory <= line_base(rd_tag[victim], idx_q);
                     mem_wdata      <= rd_line[victim];
                     state          <= ST_WRITEBACK;
                  end else begin
                     readM          <= 1'b1;
                     address_memory <= line_base(tag_q, idx_q);
                     state          <= ST_FILL;
                  end
               end
            end
            ST_WRITEBACK: begin
               if (mem_ack) begin
                  writeM         <= 1'b0;
                  readM          <= 1'b1;
                  address_memory <= line_base(tag_q, idx_q);
                  state          <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (mem_ack) begin
                  readM      <= 1'b0;
                  lru[idx_q] <= ~way_q;
                  state      <= ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               ready_cache <= 1'b1;
               doneWrite   <= op_write_q;
               rdata_cache <= get_word(rd_line[way_q], off_q);
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_cache.sv
// Directed bench for mem_cache: a 2-way instance (dut_a) and a 1-way
// instance (dut_b), each with its own memory responder.
module tb_mem_cache;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        read_a = 1'b0, write_a = 1'b0, read_b = 1'b0, write_b = 1'b0;
   logic [15:0] address_cache = '0, wdata_cache = '0;

   logic [15:0] rdata_a, rdata_b, addr_mem_a, addr_mem_b;
   logic        ready_a, ready_b, done_a, done_b;
   logic        readM_a, readM_b, writeM_a, writeM_b;
   logic [63:0] mem_wdata_a, mem_wdata_b;
   logic [63:0] mem_rdata_a = '0, mem_rdata_b = '0;
   logic        mem_ack_a = 1'b0, mem_ack_b = 1'b0;
   logic [15:0] hit_a, hit_b, acc_a, acc_b;

   always #5 clk = ~clk;

   mem_cache #(.WORD_SIZE(16), .WAYS(2), .SETS(4), .LINE_WORDS(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .read_cache(read_a), .write_cache(write_a),
      .address_cache(address_cache), .wdata_cache(wdata_cache), .rdata_cache(rdata_a),
      .ready_cache(ready_a), .doneWrite(done_a), .address_memory(addr_mem_a),
      .readM(readM_a), .writeM(writeM_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
      .mem_ack(mem_ack_a), .hit_count(hit_a), .access_count(acc_a));

   mem_cache #(.WORD_SIZE(16), .WAYS(1), .SETS(4), .LINE_WORDS(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .read_cache(read_b), .write_cache(write_b),
      .address_cache(address_cache), .wdata_cache(wdata_cache), .rdata_cache(rdata_b),
      .ready_cache(ready_b), .doneWrite(done_b), .address_memory(addr_mem_b),
      .readM(readM_b), .writeM(writeM_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
      .mem_ack(mem_ack_b), .hit_count(hit_b), .access_count(acc_b));

   // Memory contents: line 0x0014 is fixed by the test plan, every other
   // line holds word i = 0xA000 + base + i.
   function automatic logic [63:0] fill_line(input logic [15:0] base);
      if (base == 16'h0014) return 64'h4444_3333_2222_1111;
      return {16'hA000 + base + 16'd3, 16'hA000 + base + 16'd2,
              16'hA000 + base + 16'd1, 16'hA000 + base};
   endfunction

   int   ack_delay = 3;
   logic ack_hold  = 1'b0;
   int   wait_a = 0, wait_b = 0;

   always begin
      @(posedge clk); #1;
      if (mem_ack_a) mem_ack_a = 1'b0;
      else if ((readM_a || writeM_a) && !ack_hold) begin
         if (wait_a >= ack_delay) begin
            mem_ack_a = 1'b1; mem_rdata_a = fill_line(addr_mem_a); wait_a = 0;
         end else wait_a++;
      end else wait_a = 0;
   end

   always begin
      @(posedge clk); #1;
      if (mem_ack_b) mem_ack_b = 1'b0;
      else if ((readM_b || writeM_b) && !ack_hold) begin
         if (wait_b >= ack_delay) begin
            mem_ack_b = 1'b1; mem_rdata_b = fill_line(addr_mem_b); wait_b = 0;
         end else wait_b++;
      end else wait_b = 0;
   end

   // Views of whichever instance the current request targets.
   logic use_b = 1'b0;
   wire        cur_ready  = use_b ? ready_b    : ready_a;
   wire        cur_done   = use_b ? done_b     : done_a;
   wire [15:0] cur_rdata  = use_b ? rdata_b    : rdata_a;
   wire        cur_readM  = use_b ? readM_b    : readM_a;
   wire        cur_writeM = use_b ? writeM_b   : writeM_a;
   wire [15:0] cur_amem   = use_b ? addr_mem_b : addr_mem_a;
   wire [63:0] cur_mwdata = use_b ? mem_wdata_b : mem_wdata_a;

   int errors = 0;
   int checks = 0;
   bit overlap = 1'b0;

   // Results of the last request.
   logic [15:0] r_rdata, r_fill_addr, r_wb_addr;
   logic [63:0] r_wb_data;
   logic        r_done, r_fill_after_wb;
   int          r_lat, r_fills, r_wbs;

   task automatic do_req(input bit on_b, input bit is_wr, input logic [15:0] addr,
                         input logic [15:0] wd);
      int cnt;
      bit got, prev_r, prev_w;
      @(posedge clk); #1;
      use_b = on_b;
      r_fills = 0; r_wbs = 0; r_lat = -1; r_done = 1'b0; r_rdata = 'x;
      r_fill_addr = 'x; r_wb_addr = 'x; r_wb_data = 'x; r_fill_after_wb = 1'b0;
      address_cache = addr; wdata_cache = wd;
      if (on_b) begin read_b = !is_wr; write_b = is_wr; end
      else      begin read_a = !is_wr; write_a = is_wr; end
      got = 0; cnt = 0; prev_r = 0; prev_w = 0;
      while (!got && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
         if (cur_readM && cur_writeM) overlap = 1'b1;
         if (cur_writeM && !prev_w) begin
            r_wbs++; r_wb_addr = cur_amem; r_wb_data = cur_mwdata;
         end
         if (cur_readM && !prev_r) begin
            r_fills++; r_fill_addr = cur_amem; r_fill_after_wb = (r_wbs > 0);
         end
         prev_r = cur_readM; prev_w = cur_writeM;
         if (cur_ready) begin
            got = 1; r_lat = cnt - 1; r_rdata = cur_rdata; r_done = cur_done;
         end
      end
      read_a = 0; write_a = 0; read_b = 0; write_b = 0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL req_timeout addr=%h: no ready_cache within 200 cycles", addr);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #3;
      reset_n = 1'b1;
      @(posedge clk); #3;
      reset_n = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
      #1;
      checks++; if ({readM_a, writeM_a, ready_a, done_a} !== 4'b0) begin errors++;
         $display("FAIL reset_ctrl got=%b required=0000", {readM_a, writeM_a, ready_a, done_a}); end
      checks++; if ({hit_a, acc_a} !== 32'h0) begin errors++;
         $display("FAIL reset_counters got hit=%h acc=%h required 0", hit_a, acc_a); end
      checks++; if ({rdata_a, addr_mem_a} !== 32'h0 || mem_wdata_a !== 64'h0) begin errors++;
         $display("FAIL reset_data got rdata=%h amem=%h wdata=%h required 0", rdata_a, addr_mem_a, mem_wdata_a); end
      checks++; if ({readM_b, writeM_b, ready_b, hit_b, acc_b} !== 35'h0) begin errors++;
         $display("FAIL reset_b got readM=%b writeM=%b ready=%b hit=%h acc=%h required 0", readM_b, writeM_b, ready_b, hit_b, acc_b); end
   endtask

   task automatic test_cold_read();
      do_req(0, 0, 16'h0014, 16'h0);
      checks++; if (r_fills !== 1 || r_fill_addr !== 16'h0014) begin errors++;
         $display("FAIL cold_fill got fills=%0d addr=%h required 1/0014", r_fills, r_fill_addr); end
      checks++; if (r_rdata !== 16'h1111 || r_done !== 1'b0) begin errors++;
         $display("FAIL cold_rdata got %h done=%b required 1111 done=0", r_rdata, r_done); end
      checks++; if (r_lat !== 6) begin errors++;
         $display("FAIL cold_latency got %0d required 6", r_lat); end
      do_req(0, 0, 16'h0016, 16'h0);
      checks++; if (r_fills !== 0 || r_rdata !== 16'h3333) begin errors++;
         $display("FAIL hit_read got fills=%0d rdata=%h required 0/3333", r_fills, r_rdata); end
      checks++; if (r_lat !== 2) begin errors++;
         $display("FAIL hit_latency got %0d required 2", r_lat); end
      checks++; if (hit_a !== 16'd1 || acc_a !== 16'd2) begin errors++;
         $display("FAIL hit_counters got hit=%0d acc=%0d required 1/2", hit_a, acc_a); end
   endtask

   task automatic test_write_hit();
      do_req(0, 1, 16'h0015, 16'hBEEF);
      checks++; if (r_wbs !== 0 || r_fills !== 0) begin errors++;
         $display("FAIL write_hit_mem got wbs=%0d fills=%0d required 0/0", r_wbs, r_fills); end
      checks++; if (r_done !== 1'b1 || r_rdata !== 16'hBEEF) begin errors++;
         $display("FAIL write_done got done=%b rdata=%h required 1/BEEF", r_done, r_rdata); end
      do_req(0, 0, 16'h0015, 16'h0);
      checks++; if (r_rdata !== 16'hBEEF || r_done !== 1'b0) begin errors++;
         $display("FAIL read_after_write got %h done=%b required BEEF/0", r_rdata, r_done); end
   endtask

   task automatic test_eviction();
      do_req(0, 0, 16'h0054, 16'h0);
      checks++; if (r_fills !== 1 || r_wbs !== 0 || r_fill_addr !== 16'h0054 || r_rdata !== 16'hA054) begin errors++;
         $display("FAIL second_way got fills=%0d wbs=%0d addr=%h rdata=%h required 1/0/0054/A054",
                  r_fills, r_wbs, r_fill_addr, r_rdata); end
      do_req(0, 0, 16'h0094, 16'h0);
      checks++; if (r_wbs !== 1 || r_wb_addr !== 16'h0014) begin errors++;
         $display("FAIL wb_addr got wbs=%0d addr=%h required 1/0014", r_wbs, r_wb_addr); end
      checks++; if (r_wb_data !== 64'h4444_3333_BEEF_1111) begin errors++;
         $display("FAIL wb_data got %h required 44443333BEEF1111", r_wb_data); end
      checks++; if (r_fills !== 1 || r_fill_addr !== 16'h0094 || !r_fill_after_wb) begin errors++;
         $display("FAIL wb_then_fill got fills=%0d addr=%h after_wb=%b required 1/0094/1",
                  r_fills, r_fill_addr, r_fill_after_wb); end
      checks++; if (r_rdata !== 16'hA094 || r_lat !== 11) begin errors++;
         $display("FAIL dirty_miss got rdata=%h lat=%0d required A094/11", r_rdata, r_lat); end
      do_req(0, 0, 16'h0054, 16'h0);
      checks++; if (r_fills !== 0 || r_rdata !== 16'hA054 || r_lat !== 2) begin errors++;
         $display("FAIL lru_keep got fills=%0d rdata=%h lat=%0d required 0/A054/2", r_fills, r_rdata, r_lat); end
      checks++; if (hit_a !== 16'd4 || acc_a !== 16'd7) begin errors++;
         $display("FAIL evict_counters got hit=%0d acc=%0d required 4/7", hit_a, acc_a); end
   endtask

   // Miss at 0x00D4 with the ack withheld, then reset while readM is high.
   task automatic test_withhold_and_reset();
      int cnt;
      bit stable;
      logic [15:0] snap_h, snap_a;
      @(posedge clk); #1;
      use_b = 0; ack_hold = 1'b1;
      address_cache = 16'h00D4; read_a = 1'b1;
      cnt = 0;
      while (!readM_a && cnt < 10) begin @(posedge clk); #1; cnt++; end
      checks++; if (readM_a !== 1'b1 || addr_mem_a !== 16'h00D4) begin errors++;
         $display("FAIL hold_start got readM=%b amem=%h required 1/00D4", readM_a, addr_mem_a); end
      snap_h = hit_a; snap_a = acc_a; stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (readM_a !== 1'b1 || writeM_a !== 1'b0 || addr_mem_a !== 16'h00D4 || ready_a !== 1'b0 ||
             hit_a !== snap_h || acc_a !== snap_a) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1 || acc_a !== 16'd8) begin errors++;
         $display("FAIL hold_stable got stable=%b acc=%0d required 1/8", stable, acc_a); end
      #2; reset_n = 1'b1; #1;
      checks++; if (readM_a !== 1'b0 || acc_a !== 16'd0 || hit_a !== 16'd0) begin errors++;
         $display("FAIL reset_mid_miss got readM=%b acc=%0d hit=%0d required 0/0/0", readM_a, acc_a, hit_a); end
      read_a = 1'b0;
      @(posedge clk); #3;
      reset_n = 1'b0; ack_hold = 1'b0;
      do_req(0, 0, 16'h0014, 16'h0);
      checks++; if (r_fills !== 1 || r_fill_addr !== 16'h0014 || r_rdata !== 16'h1111) begin errors++;
         $display("FAIL post_reset_miss got fills=%0d addr=%h rdata=%h required 1/0014/1111",
                  r_fills, r_fill_addr, r_rdata); end
      checks++; if (hit_a !== 16'd0 || acc_a !== 16'd1) begin errors++;
         $display("FAIL post_reset_counters got hit=%0d acc=%0d required 0/1", hit_a, acc_a); end
   endtask

   task automatic test_one_way();
      int total_fills;
      int bad_data;
      logic [15:0] a, exp;
      pulse_reset();
      total_fills = 0; bad_data = 0;
      for (int i = 0; i < 4; i++) begin
         a   = (i % 2 == 1) ? 16'h0054 : 16'h0014;
         exp = (i % 2 == 1) ? 16'hA054 : 16'h1111;
         do_req(1, 0, a, 16'h0);
         total_fills += r_fills;
         if (r_rdata !== exp) bad_data++;
      end
      checks++; if (total_fills !== 4) begin errors++;
         $display("FAIL one_way_fills got %0d required 4", total_fills); end
      checks++; if (bad_data !== 0) begin errors++;
         $display("FAIL one_way_rdata got %0d wrong reads required 0", bad_data); end
      checks++; if (hit_b !== 16'd0 || acc_b !== 16'd4) begin errors++;
         $display("FAIL one_way_counters got hit=%0d acc=%0d required 0/4", hit_b, acc_b); end
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_write_hit();
      test_eviction();
      test_withhold_and_reset();
      test_one_way();
      checks++; if (overlap !== 1'b0) begin errors++;
         $display("FAIL req_overlap got readM&writeM=%b required 0", overlap); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_cache.md
Name: mem_cache

Overview:
- Parametrised write-back, write-allocate, set-associative cache (1 or 2 ways).
- Sits between the pipelined datapath and the line-wide memory port. One instance serves instruction fetch; one serves data.
- Next-generation cache: configurable sets, line length and associativity, LRU replacement, dirty-victim writeback, memory ack handshake, hit/access counters.

Parameters:
- WORD_SIZE, 16, data and address word width.
- WAYS, 2, associativity; legal values 1 and 2.
- SETS, 4, number of sets; power of two, at least 2.
- LINE_WORDS, 4, words per line; power of two; memory bus is LINE_WORDS*WORD_SIZE wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-high reset.
- read_cache  in  1  read request; held stable until ready_cache.
- write_cache  in  1  write request; held stable until ready_cache.
- address_cache  in  WORD_SIZE  word address.
- wdata_cache  in  WORD_SIZE  store data.
- rdata_cache  out  WORD_SIZE  load data; valid while ready_cache=1.
- ready_cache  out  1  one-cycle completion pulse.
- doneWrite  out  1  equals ready_cache AND the accepted operation is a write.
- address_memory  out  WORD_SIZE  line base address (offset bits zero).
- readM  out  1  line fill request.
- writeM  out  1  line writeback request.
- mem_wdata  out  LINE_WORDS*WORD_SIZE  victim line; word 0 in the LSBs.
- mem_rdata  in  LINE_WORDS*WORD_SIZE  fill line; word 0 in the LSBs.
- mem_ack  in  1  memory completed the current readM/writeM; sampled only while that request is high.
- hit_count  out  16  hits since reset; wraps.
- access_count  out  16  accepted requests since reset; wraps.

Behaviour:
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining bits.
- Reset: all valid, dirty and LRU bits cleared; FSM to IDLE. All outputs are 0 (readM, writeM, ready_cache, doneWrite, counters, rdata_cache, address_memory, mem_wdata). Takes effect immediately, including mid-miss; any in-flight memory transaction is abandoned.
- FSM states: IDLE, TAG, WRITEBACK, FILL, RESPOND.
- IDLE:
  - If read_cache or write_cache is high, latch address, data and op, increment access_count, go to TAG.
  - If both are high, treat the request as a write.
- TAG: compare the tag against all valid ways of the indexed set.
  - Hit: increment hit_count. On a write, update the word and set dirty. Point LRU at the other way. Go to RESPOND.
  - Miss: choose a victim — first invalid way (way 0 preferred), otherwise the LRU way. Dirty victim goes to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - writeM=1, address_memory = victim tag/index base, mem_wdata = victim line, held stable.
  - On mem_ack: clear dirty, drop writeM the next cycle, go to FILL.
- FILL:
  - readM=1, address_memory = request line base.
  - On mem_ack: install mem_rdata, tag and valid; dirty = 0. Then apply a pending write (word updated, dirty = 1). Update LRU. Go to RESPOND.
- RESPOND: ready_cache=1 for exactly one cycle, rdata_cache = the addressed word (post-write value for writes), doneWrite per definition; then return to IDLE.
- Latency:
  - Hit: ready_cache high 2 cycles after the accepting edge.
  - Clean miss: ready_cache high 2 cycles + fill wait + 1.
  - Dirty miss: adds the writeback wait plus 1 cycle.
- readM and writeM are never high together, and each is held until mem_ack. mem_ack in IDLE, TAG or RESPOND is ignored.
- WAYS=1: the LRU bit is unused and the victim is always way 0.
- Requester changes inputs before ready_cache: ignored; latched values are used.

Decomposition:
- Shared package (cache_pkg): FSM state encodings, WORD_SIZE, and the log2 helper for field widths.
- One sub-module, cache_way_array: per-way tag/valid/dirty/data storage with an index read port and a single write port. Instantiated WAYS times.
- LRU bits and the FSM stay in mem_cache.

Test Plan:
- Config for all scenarios: WAYS=2, SETS=4, LINE_WORDS=4; 0x0014/0x0054/0x0094 all map to index 1.
- Cold read 0x0014; mem_ack 3 cycles after readM with line {0x1111,0x2222,0x3333,0x4444} -> address_memory=0x0014, rdata 0x1111 with ready pulse. Then read 0x0016 -> no readM, rdata 0x3333 two cycles after acceptance; hit_count=1, access_count=2.
- Write 0x0015=0xBEEF after the cold fill -> no writeM, doneWrite pulses. Then read 0x0015 -> 0xBEEF.
- After the above, read 0x0054 then read 0x0094 -> writeM with address_memory=0x0014 and mem_wdata word1=0xBEEF; after mem_ack, readM with 0x0094. A following read of 0x0054 hits.
- WAYS=1: alternate reads 0x0014/0x0054 four times -> 4 readM fills, hit_count=0.
- Assert reset_n while readM=1 awaiting ack -> readM=0 in the same cycle. Afterwards, read 0x0014 misses again.
- Withhold mem_ack 10 cycles -> readM and address_memory held stable, ready_cache stays 0, counters unchanged.
